// File: rtl/vdot_stream.sv
// Serial FP16 dot product: streams LEN A/B pairs, multiplies each pair, accumulates into one half-precision result.
// Latency: done in cycle LEN+1+PIPE after the start edge with in_valid held high; each gap cycle adds one.
// Backpressure: in_ready depends only on state and element count; pairs are ignored while it is low.
module vdot_stream #(
  parameter  int LEN   = 16,
  parameter  int PIPE  = 1,
  localparam int CNT_W = $clog2(LEN+1)
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start,
  input  logic        chain,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] out,
  output logic        V,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  // FP16 multiply, subnormals flushed to zero, round to nearest even. Returns {overflow, result}.
  function automatic logic [16:0] fp_mul(input logic [15:0] x, input logic [15:0] y);
    logic              s;
    logic [4:0]        ex, ey;
    logic [21:0]       p;
    logic signed [7:0] e;
    logic [10:0]       m;
    logic              g, st;
    logic [11:0]       r;
    logic [16:0]       res;
    s  = x[15] ^ y[15];
    ex = x[14:10];
    ey = y[14:10];
    p  = {11'b0, 1'b1, x[9:0]} * {11'b0, 1'b1, y[9:0]};
    e  = $signed({3'b000, ex}) + $signed({3'b000, ey}) - 8'sd15;
    if (p[21]) begin
      m  = p[21:11];
      g  = p[10];
      st = |p[9:0];
      e  = e + 8'sd1;
    end else begin
      m  = p[20:10];
      g  = p[9];
      st = |p[8:0];
    end
    r = {1'b0, m} + {11'b0, g & (st | m[0])};
    if (r[11]) begin
      r = r >> 1;
      e = e + 8'sd1;
    end
    if (ex == 5'd31 || ey == 5'd31) begin
      // Inf/NaN operands propagate without raising overflow; Inf*0 is NaN.
      if ((ex == 5'd31 && x[9:0] != 10'd0) || (ey == 5'd31 && y[9:0] != 10'd0) ||
          ex == 5'd0 || ey == 5'd0)
        res = {1'b0, 16'h7E00};
      else
        res = {1'b0, s, 5'h1F, 10'h000};
    end else if (ex == 5'd0 || ey == 5'd0) begin
      res = {1'b0, s, 15'h0000};
    end else if (e >= 8'sd31) begin
      res = {1'b1, s, 5'h1F, 10'h000};
    end else if (e <= 8'sd0) begin
      res = {1'b0, s, 15'h0000};
    end else begin
      res = {1'b0, s, e[4:0], r[9:0]};
    end
    return res;
  endfunction

  // FP16 add, subnormals flushed to zero, round to nearest even. Returns {overflow, result}.
  function automatic logic [16:0] fp_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0]       a, b;
    logic [4:0]        ea, eb, d;
    logic [3:0]        ds, lz;
    logic [13:0]       ma, mb, n;
    logic [27:0]       ext;
    logic [14:0]       sum;
    logic signed [7:0] e;
    logic              found;
    logic [11:0]       r;
    logic [16:0]       res;
    // Order by magnitude so the alignment shift is always applied to b.
    if (x[14:0] >= y[14:0]) begin
      a = x;
      b = y;
    end else begin
      a = y;
      b = x;
    end
    ea  = a[14:10];
    eb  = b[14:10];
    ma  = {1'b1, a[9:0], 3'b000};
    mb  = {1'b1, b[9:0], 3'b000};
    d   = ea - eb;
    ds  = (d > 5'd15) ? 4'd15 : d[3:0];
    ext = {mb, 14'b0} >> ds;
    mb  = ext[27:14] | {13'b0, |ext[13:0]};
    e   = $signed({3'b000, ea});
    lz  = 4'd0;
    found = 1'b0;
    sum = 15'd0;
    if (a[15] == b[15]) begin
      sum = {1'b0, ma} + {1'b0, mb};
      if (sum[14]) begin
        n = sum[14:1] | {13'b0, sum[0]};
        e = e + 8'sd1;
      end else begin
        n = sum[13:0];
      end
    end else begin
      n = ma - mb;
      for (int i = 13; i >= 0; i--) begin
        if (!found) begin
          if (n[i]) found = 1'b1;
          else      lz = lz + 4'd1;
        end
      end
      n = n << lz;
      e = e - $signed({4'b0000, lz});
    end
    r = {1'b0, n[13:3]} + {11'b0, n[2] & (n[1] | n[0] | n[3])};
    if (r[11]) begin
      r = r >> 1;
      e = e + 8'sd1;
    end
    if (ea == 5'd31) begin
      // a holds the larger code, so a NaN or Inf operand always lands in a.
      if (a[9:0] != 10'd0 || (eb == 5'd31 && a[15] != b[15]))
        res = {1'b0, 16'h7E00};
      else
        res = {1'b0, a};
    end else if (ea == 5'd0) begin
      res = {1'b0, a[15] & b[15], 15'h0000};
    end else if (eb == 5'd0) begin
      res = {1'b0, a};
    end else if (a[15] != b[15] && !found) begin
      res = {1'b0, 16'h0000};
    end else if (e >= 8'sd31) begin
      res = {1'b1, a[15], 5'h1F, 10'h000};
    end else if (e <= 8'sd0) begin
      res = {1'b0, a[15], 15'h0000};
    end else begin
      res = {1'b0, a[15], e[4:0], r[9:0]};
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      out_q, out_d;
  logic             v_q, v_d;
  logic [15:0]      prod_q, prod_d;
  logic             prod_v_q, prod_v_d;

  logic        accept;
  logic [16:0] mul_r;
  logic [16:0] add_r;
  logic [15:0] add_a;

  assign in_ready = (state_q == S_RUN) && (cnt_q < LEN_C);
  assign accept   = in_ready && in_valid;
  assign mul_r    = fp_mul(A, B);
  // With the pipeline register the adder consumes last cycle's product, otherwise the live one.
  assign add_a    = (PIPE != 0) ? prod_q : mul_r[15:0];
  assign add_r    = fp_add(add_a, out_q);

  assign out  = out_q;
  assign V    = v_q;
  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  // Next-state and datapath update; abort overrides everything except a pending product add.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    v_d      = v_q;
    prod_d   = prod_q;
    prod_v_d = prod_v_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          v_d     = 1'b0;
          out_d   = chain ? out_q : 16'h0000;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          v_d   = v_d | mul_r[16];
          if (PIPE != 0) begin
            prod_d = mul_r[15:0];
          end else begin
            out_d = add_r[15:0];
            v_d   = v_d | add_r[16];
          end
          if (cnt_q == LEN_C - 1'b1) state_d = (PIPE != 0) ? S_DRAIN : S_DONE;
        end
        if (PIPE != 0) begin
          prod_v_d = accept;
          if (prod_v_q) begin
            out_d = add_r[15:0];
            v_d   = v_d | add_r[16];
          end
        end
      end
      S_DRAIN: begin
        if (prod_v_q) begin
          out_d = add_r[15:0];
          v_d   = v_d | add_r[16];
        end
        prod_v_d = 1'b0;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      prod_v_d = 1'b0;
      out_d    = ((PIPE != 0) && prod_v_q) ? add_r[15:0] : out_q;
      v_d      = v_q | (((PIPE != 0) && prod_v_q) ? add_r[16] : 1'b0);
    end
  end

  // State, counter, accumulator and product registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      out_q    <= 16'h0000;
      v_q      <= 1'b0;
      prod_q   <= 16'h0000;
      prod_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      v_q      <= v_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end

endmodule

// File: tb/tb_vdot_stream.sv
// Directed bench for vdot_stream: three instances (LEN=16/PIPE=1, LEN=4/PIPE=1, LEN=1/PIPE=0).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Only the selected instance gets start; the others sit idle and ignore the shared stream.
module tb_vdot_stream;

  logic        Clk;
  logic        Rst_n;
  logic [2:0]  start_v;
  logic        chain;
  logic        abort;
  logic        in_valid;
  logic [15:0] A, B;

  logic        rdy0, rdy1, rdy2;
  logic [15:0] out0, out1, out2;
  logic        v0, v1, v2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;
  int len_m;
  logic v_at2, v_at_done, busy_after_abort, early_drop;
  int d;

  logic [15:0] m_out;
  logic        m_v, m_busy, m_done, m_rdy;
  assign m_out  = (sel == 0) ? out0  : (sel == 1) ? out1  : out2;
  assign m_v    = (sel == 0) ? v0    : (sel == 1) ? v1    : v2;
  assign m_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign m_done = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  assign m_rdy  = (sel == 0) ? rdy0  : (sel == 1) ? rdy1  : rdy2;
  assign len_m  = (sel == 0) ? 16 : (sel == 1) ? 4 : 1;

  vdot_stream #(.LEN(16), .PIPE(1)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .start(start_v[0]), .chain(chain), .abort(abort),
    .in_valid(in_valid), .in_ready(rdy0), .A(A), .B(B),
    .out(out0), .V(v0), .busy(busy0), .done(done0));

  vdot_stream #(.LEN(4), .PIPE(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .start(start_v[1]), .chain(chain), .abort(abort),
    .in_valid(in_valid), .in_ready(rdy1), .A(A), .B(B),
    .out(out1), .V(v1), .busy(busy1), .done(done1));

  vdot_stream #(.LEN(1), .PIPE(0)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .start(start_v[2]), .chain(chain), .abort(abort),
    .in_valid(in_valid), .in_ready(rdy2), .A(A), .B(B),
    .out(out2), .V(v2), .busy(busy2), .done(done2));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One dot product on instance s: first pair (fa,fb), then (ra,rb) for the rest.
  // gap=1 drops in_valid on even cycles; abort_at>0 raises abort in that cycle.
  // done_cyc is the cycle (start edge = 0) in which done was seen, -1 if never.
  task automatic run_dot(input int s, input logic ch, input bit gap,
                         input logic [15:0] fa, input logic [15:0] fb,
                         input logic [15:0] ra, input logic [15:0] rb,
                         input int abort_at, output int done_cyc);
    int acc;
    int cyc;
    done_cyc = -1;
    acc = 0;
    early_drop = 1'b0;
    v_at2 = 1'b0;
    v_at_done = 1'b0;
    busy_after_abort = 1'b1;
    sel = s;
    @(posedge Clk); #1;
    start_v = 3'b000;
    start_v[s] = 1'b1;
    chain = ch;
    cyc = 0;
    @(posedge Clk); #1;
    start_v = 3'b000;
    chain = 1'b0;
    cyc = 1;
    while (cyc < 80 && done_cyc < 0) begin
      in_valid = !(gap && (cyc % 2 == 0));
      A = (acc == 0) ? fa : ra;
      B = (acc == 0) ? fb : rb;
      abort = (cyc == abort_at);
      @(negedge Clk);
      if (cyc == 2) v_at2 = m_v;
      if (!m_rdy && acc < len_m && abort_at == 0) early_drop = 1'b1;
      if (m_rdy && in_valid) acc++;
      if (m_done) begin
        done_cyc = cyc;
        v_at_done = m_v;
      end
      if (abort_at != 0 && cyc == abort_at + 1) busy_after_abort = m_busy;
      if (abort_at != 0 && cyc >= abort_at + 4) break;
      @(posedge Clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0;
    start_v = 3'b000;
    chain = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    A = 16'h0000;
    B = 16'h0000;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_out",   {16'h0, out0}, 32'h0);
    check("rst_v",     {31'h0, v0},   32'h0);
    check("rst_done",  {31'h0, done0}, 32'h0);
    check("rst_busy",  {31'h0, busy0}, 32'h0);
    check("rst_ready", {31'h0, rdy0}, 32'h0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // 16 x (1.0*1.0) = 16.0
    run_dot(0, 1'b0, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0, d);
    check("ones_done_cyc", d, 32'd18);
    check("ones_out", {16'h0, m_out}, 32'h4C00);
    check("ones_v", {31'h0, v_at_done}, 32'h0);
    @(negedge Clk);
    check("ones_done_pulse", {31'h0, m_done}, 32'h0);
    check("ones_busy_after", {31'h0, m_busy}, 32'h0);
    check("ones_out_hold", {16'h0, m_out}, 32'h4C00);

    // LEN=4, 4 x (2.0*3.0) = 24.0 with alternate-cycle gaps
    run_dot(1, 1'b0, 1'b1, 16'h4000, 16'h4200, 16'h4000, 16'h4200, 0, d);
    check("gap_done_cyc", d, 32'd9);
    check("gap_out", {16'h0, m_out}, 32'h4E00);
    check("gap_ready_early_drop", {31'h0, early_drop}, 32'h0);

    // chained second run on top of 16.0 gives 32.0
    run_dot(0, 1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0, d);
    check("chain_done_cyc", d, 32'd18);
    check("chain_out", {16'h0, m_out}, 32'h5000);

    // 65504^2 overflows to +Inf; zeros afterwards keep Inf without clearing V
    run_dot(0, 1'b0, 1'b0, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h0000, 0, d);
    check("ovf_done_cyc", d, 32'd18);
    check("ovf_v_cyc2", {31'h0, v_at2}, 32'h1);
    check("ovf_v_done", {31'h0, v_at_done}, 32'h1);
    check("ovf_out", {16'h0, m_out}, 32'h7C00);

    // abort in cycle 5: four accepted elements survive, no done, V cleared by start
    run_dot(0, 1'b0, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 5, d);
    check("abort_no_done", d, 32'hFFFF_FFFF);
    check("abort_busy", {31'h0, busy_after_abort}, 32'h0);
    check("abort_out", {16'h0, m_out}, 32'h4400);
    check("abort_v_cleared", {31'h0, m_v}, 32'h0);
    run_dot(0, 1'b0, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0, d);
    check("post_abort_done_cyc", d, 32'd18);
    check("post_abort_out", {16'h0, m_out}, 32'h4C00);

    // asynchronous reset in the middle of a run
    sel = 0;
    @(posedge Clk); #1;
    start_v = 3'b001;
    @(posedge Clk); #1;
    start_v = 3'b000;
    in_valid = 1'b1;
    A = 16'h7BFF;
    B = 16'h7BFF;
    @(posedge Clk); #1;
    A = 16'h3C00;
    B = 16'h3C00;
    @(posedge Clk); #2;
    check("midrst_v_before", {31'h0, v0}, 32'h1);
    Rst_n = 1'b0;
    #1;
    check("midrst_out", {16'h0, out0}, 32'h0);
    check("midrst_v", {31'h0, v0}, 32'h0);
    check("midrst_busy", {31'h0, busy0}, 32'h0);
    check("midrst_ready", {31'h0, rdy0}, 32'h0);
    in_valid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    run_dot(0, 1'b0, 1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0, d);
    check("post_rst_done_cyc", d, 32'd18);
    check("post_rst_out", {16'h0, m_out}, 32'h4C00);

    // LEN=1, combinational multiply-add: 2.0*2.0 = 4.0, done in cycle 2
    run_dot(2, 1'b0, 1'b0, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 0, d);
    check("len1_done_cyc", d, 32'd2);
    check("len1_out", {16'h0, m_out}, 32'h4400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
